// File: rtl/dst_buf_if.sv
// Core-write, frame-done and drain-stream signals of the dst_buf ping-pong result buffer.
interface dst_buf_if #(
  parameter int ADDR_W = 10
);
  logic              exec_dst_v;
  logic [ADDR_W:0]   exec_dst_addr;
  logic [31:0]       exec_dst_data;
  logic              exec_done;
  logic [ADDR_W:0]   drain_len;
  logic              p;
  logic              dst_v;
  logic [ADDR_W-1:0] dst_a;
  logic [63:0]       dst_d;
  logic              dst_ready;
  logic              busy;
  logic              overrun;

  modport master (
    output exec_dst_v, exec_dst_addr, exec_dst_data, exec_done, drain_len, dst_ready,
    input  p, dst_v, dst_a, dst_d, busy, overrun
  );

  modport slave (
    input  exec_dst_v, exec_dst_addr, exec_dst_data, exec_done, drain_len, dst_ready,
    output p, dst_v, dst_a, dst_d, busy, overrun
  );
endinterface

// File: rtl/dst_buf.sv
// Ping-pong result buffer: cores fill bank p, drain FSM streams bank ~p as 64-bit words.
// Define DST_BUF_CLEAR_EN to zero each drained location on its handshake.
module dst_buf #(
  parameter int ADDR_W = 10
) (
  input  logic      clk,
  input  logic      rst_n,
  dst_buf_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t            state, state_nxt;
  logic              p_q;
  logic              ovr_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W:0]   len_sat;
  logic [ADDR_W-1:0] dst_a_p1;
  logic [63:0]       dst_d_p1;
  logic              vld_p1;
  logic              busy_c;
  logic              accept;
  logic              hs;
  logic              last;

  logic [31:0] mem_e [2][DEPTH];
  logic [31:0] mem_o [2][DEPTH];

  assign cnt_inc = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
  // Any length with the top bit set is clamped to a full bank.
  assign len_sat = bus.drain_len[ADDR_W] ? {1'b1, {ADDR_W{1'b0}}} : bus.drain_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (bus.drain_len != '0)) state_nxt = FETCH;
      FETCH:   state_nxt = SEND;
      SEND:    if (hs) state_nxt = last ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state != IDLE);
    vld_p1 = (state == SEND);
    accept = bus.exec_done && !busy_c;
    hs     = vld_p1 && bus.dst_ready;
    last   = (cnt_inc == len_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= 1'b0;
      ovr_q <= 1'b0;
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        p_q   <= ~p_q;
        len_q <= len_sat;
        cnt_q <= '0;
      end else if (hs) begin
        cnt_q <= cnt_inc;
      end
      if (bus.exec_done && busy_c) ovr_q <= 1'b1;
    end
  end

  // FETCH -> SEND: both halves of the draining bank are captured and held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_a_p1 <= '0;
      dst_d_p1 <= '0;
    end else if (state == FETCH) begin
      dst_a_p1 <= cnt_q[ADDR_W-1:0];
      dst_d_p1 <= {mem_o[~p_q][cnt_q[ADDR_W-1:0]], mem_e[~p_q][cnt_q[ADDR_W-1:0]]};
    end
  end

  // Cores only ever write bank p; the drain side only ever touches bank ~p.
  always_ff @(posedge clk) begin
    if (bus.exec_dst_v) begin
      if (bus.exec_dst_addr[0]) mem_o[p_q][bus.exec_dst_addr[ADDR_W:1]] <= bus.exec_dst_data;
      else                      mem_e[p_q][bus.exec_dst_addr[ADDR_W:1]] <= bus.exec_dst_data;
    end
`ifdef DST_BUF_CLEAR_EN
    if (hs) begin
      mem_e[~p_q][dst_a_p1] <= '0;
      mem_o[~p_q][dst_a_p1] <= '0;
    end
`endif
  end

  assign bus.p       = p_q;
  assign bus.dst_v   = vld_p1;
  assign bus.dst_a   = dst_a_p1;
  assign bus.dst_d   = dst_d_p1;
  assign bus.busy    = busy_c;
  assign bus.overrun = ovr_q;
endmodule
